// File: rtl/riscv_pkg.sv
// Shared RV32 front-end constants and types.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// RV32 fetch stage: one outstanding imem request, wrong-path response dropping on redirect,
// and a single-entry registered valid/ready output toward the decoder.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_resp_valid,
  input  logic [XLEN-1:0] i_imem_resp_data,
  input  logic            i_redirect_en,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_instr_valid;

  logic            w_req_valid;
  logic [XLEN-1:0] w_redirect_target;

  // A request may only go out when the output slot is free or being drained this cycle.
  always_comb begin
    w_req_valid       = (r_state == FETCH_REQ) && !i_rst && !i_redirect_en &&
                        (!r_instr_valid || i_instr_ready);
    w_redirect_target = i_redirect_pc & ALIGN_MASK;
  end

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_pc & ALIGN_MASK;
  assign o_instr_valid    = r_instr_valid;
  assign o_instr          = r_instr;
  assign o_instr_pc       = r_instr_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= FETCH_REQ;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else if (i_redirect_en) begin
      r_pc          <= w_redirect_target;
      r_instr_valid <= 1'b0;
      // An outstanding request becomes wrong-path unless its response lands right now.
      case (r_state)
        FETCH_REQ:              r_state <= FETCH_REQ;
        FETCH_WAIT, FETCH_DROP: r_state <= i_imem_resp_valid ? FETCH_REQ : FETCH_DROP;
        default:                r_state <= FETCH_REQ;
      endcase
    end else begin
      if (r_instr_valid && i_instr_ready) begin
        r_instr_valid <= 1'b0;
      end
      case (r_state)
        FETCH_REQ: begin
          if (w_req_valid && i_imem_req_ready) begin
            r_state <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (i_imem_resp_valid) begin
            r_instr       <= i_imem_resp_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + PC_STEP;
            r_state       <= FETCH_REQ;
          end
        end
        FETCH_DROP: begin
          if (i_imem_resp_valid) begin
            r_state <= FETCH_REQ;
          end
        end
        default: r_state <= FETCH_REQ;
      endcase
    end
  end

  // Memory must never answer while nothing is outstanding.
  a_no_resp_in_req: assert property (@(posedge i_clk) disable iff (i_rst)
    !(r_state == FETCH_REQ && i_imem_resp_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a sequential-address
// reference model and a variable-latency instruction memory.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        redirEn;
  logic [31:0] redirPc;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPc;

  int testsRun    = 0;
  int testsFailed = 0;

  // Memory model state: at most one pending request, answered memLat cycles after acceptance.
  bit          memPending = 0;
  logic [31:0] memAddr    = '0;
  int          memCnt     = 0;
  int          memLat     = 1;

  // Snapshot of DUT outputs taken at the negedge of the most recent tick.
  logic        sReqValid;
  logic [31:0] sReqAddr;
  logic        sInstrValid;
  logic [31:0] sInstr;
  logic [31:0] sInstrPc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .o_imem_req_valid  (imemReqValid),
    .i_imem_req_ready  (imemReqReady),
    .o_imem_req_addr   (imemReqAddr),
    .i_imem_resp_valid (imemRespValid),
    .i_imem_resp_data  (imemRespData),
    .i_redirect_en     (redirEn),
    .i_redirect_pc     (redirPc),
    .o_instr_valid     (instrValid),
    .i_instr_ready     (instrReady),
    .o_instr           (instr),
    .o_instr_pc        (instrPc)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ MEM_XOR;
  endfunction

  // One clock cycle: drive the memory response, sample outputs mid-cycle, then advance the memory model.
  task automatic tick();
    bit deliver;
    bit accept;
    deliver = memPending && (memCnt == 0) && !rst;
    imemRespValid = deliver;
    imemRespData  = deliver ? memWord(memAddr) : $urandom();
    @(negedge clk);
    sReqValid   = imemReqValid;
    sReqAddr    = imemReqAddr;
    sInstrValid = instrValid;
    sInstr      = instr;
    sInstrPc    = instrPc;
    accept = sReqValid && imemReqReady && !rst;
    @(posedge clk);
    if (rst || deliver) memPending = 0;
    else if (memPending && memCnt > 0) memCnt--;
    if (accept) begin
      memPending = 1;
      memAddr    = sReqAddr;
      memCnt     = memLat - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirEn = 1'b0; redirPc = '0; instrReady = 1'b1; imemReqReady = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirEn = 1'b0; instrReady = 1'b1; imemReqReady = 1'b1; memLat = 1;
    tick();
    testsRun++; if (sReqValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req_valid_in_rst: got %b want 0", sReqValid); end
    testsRun++; if (sInstrValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_instr_valid_in_rst: got %b want 0", sInstrValid); end
    tick();
    rst = 1'b0;
    tick();
    testsRun++; if (sReqValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_first_req_valid: got %b want 1", sReqValid); end
    testsRun++; if (sReqAddr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_first_req_addr: got %h want 00000000", sReqAddr); end
    testsRun++; if (sInstrValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_instr_valid: got %b want 0", sInstrValid); end
    testsRun++; if (sInstr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_instr: got %h want 00000000", sInstr); end
    testsRun++; if (sInstrPc !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_instr_pc: got %h want 00000000", sInstrPc); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs[$];
    logic [31:0] words[$];
    int          cycles[$];
    do_reset();
    memLat = 1; instrReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sInstrValid) begin
        pcs.push_back(sInstrPc); words.push_back(sInstr); cycles.push_back(c);
      end
    end
    testsRun++; if (pcs.size() != 4) begin testsFailed++; $display("[TB] FAIL stream_count: got %0d want 4", pcs.size()); end
    testsRun++; if (cycles.size() == 0 || cycles[0] != 2) begin testsFailed++; $display("[TB] FAIL stream_first_latency: got %0d want 2", cycles.size() == 0 ? -1 : cycles[0]); end
    for (int i = 0; i < 4 && i < pcs.size(); i++) begin
      testsRun++; if (pcs[i] !== 32'(4 * i)) begin testsFailed++; $display("[TB] FAIL stream_pc[%0d]: got %h want %h", i, pcs[i], 32'(4 * i)); end
      testsRun++; if (words[i] !== memWord(32'(4 * i))) begin testsFailed++; $display("[TB] FAIL stream_instr[%0d]: got %h want %h", i, words[i], memWord(32'(4 * i))); end
      if (i > 0) begin
        testsRun++; if (cycles[i] - cycles[i-1] != 2) begin testsFailed++; $display("[TB] FAIL stream_gap[%0d]: got %0d want 2", i, cycles[i] - cycles[i-1]); end
      end
    end
  endtask

  task automatic test_stall();
    bit seen;
    do_reset();
    memLat = 1; instrReady = 1'b0; seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (sInstrValid) seen = 1;
    end
    testsRun++; if (!seen) begin testsFailed++; $display("[TB] FAIL stall_first_word_timeout: got 0 want 1"); end
    for (int k = 0; k < 4; k++) begin
      tick();
      testsRun++; if (sInstrValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_valid[%0d]: got %b want 1", k, sInstrValid); end
      testsRun++; if (sInstrPc !== 32'h0 || sInstr !== memWord(32'h0)) begin testsFailed++; $display("[TB] FAIL stall_hold[%0d]: got pc %h instr %h want pc 00000000 instr %h", k, sInstrPc, sInstr, memWord(32'h0)); end
      testsRun++; if (sReqValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_req_valid[%0d]: got %b want 0", k, sReqValid); end
    end
    instrReady = 1'b1;
    tick();
    testsRun++; if (sReqValid !== 1'b1 || sReqAddr !== 32'h4) begin testsFailed++; $display("[TB] FAIL stall_release_req: got valid %b addr %h want valid 1 addr 00000004", sReqValid, sReqAddr); end
  endtask

  task automatic test_redirect_wait();
    bit seen;
    do_reset();
    memLat = 3; instrReady = 1'b1;
    tick();
    testsRun++; if (sReqValid !== 1'b1 || sReqAddr !== 32'h0) begin testsFailed++; $display("[TB] FAIL rdw_first_req: got valid %b addr %h want valid 1 addr 00000000", sReqValid, sReqAddr); end
    redirEn = 1'b1; redirPc = 32'h0000_0103;
    tick();
    testsRun++; if (sReqValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rdw_req_during_redirect: got %b want 0", sReqValid); end
    redirEn = 1'b0;
    memLat = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      testsRun++; if (sReqValid !== 1'b0 || sInstrValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rdw_drop[%0d]: got req %b valid %b want 0 0", k, sReqValid, sInstrValid); end
    end
    tick();
    testsRun++; if (sReqValid !== 1'b1 || sReqAddr !== 32'h100 || sInstrValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rdw_next_req: got valid %b addr %h ivalid %b want 1 00000100 0", sReqValid, sReqAddr, sInstrValid); end
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (sInstrValid) seen = 1;
    end
    testsRun++; if (!seen || sInstrPc !== 32'h100 || sInstr !== memWord(32'h100)) begin testsFailed++; $display("[TB] FAIL rdw_first_word: got seen %0d pc %h instr %h want 1 00000100 %h", seen, sInstrPc, sInstr, memWord(32'h100)); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    memLat = 1; instrReady = 1'b1;
    tick();
    redirEn = 1'b1; redirPc = 32'h0000_020B;
    tick();
    redirEn = 1'b0;
    tick();
    testsRun++; if (sInstrValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rsc_no_valid: got %b want 0", sInstrValid); end
    testsRun++; if (sReqValid !== 1'b1 || sReqAddr !== 32'h208) begin testsFailed++; $display("[TB] FAIL rsc_next_req: got valid %b addr %h want 1 00000208", sReqValid, sReqAddr); end
    tick();
    tick();
    testsRun++; if (sInstrValid !== 1'b1 || sInstrPc !== 32'h208 || sInstr !== memWord(32'h208)) begin testsFailed++; $display("[TB] FAIL rsc_word: got valid %b pc %h instr %h want 1 00000208 %h", sInstrValid, sInstrPc, sInstr, memWord(32'h208)); end
  endtask

  task automatic test_wrap();
    do_reset();
    memLat = 1; instrReady = 1'b1;
    redirEn = 1'b1; redirPc = 32'hFFFF_FFFE;
    tick();
    testsRun++; if (sReqValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL wrap_no_req_on_redirect: got %b want 0", sReqValid); end
    redirEn = 1'b0;
    tick();
    testsRun++; if (sReqValid !== 1'b1 || sReqAddr !== 32'hFFFF_FFFC) begin testsFailed++; $display("[TB] FAIL wrap_req_top: got valid %b addr %h want 1 fffffffc", sReqValid, sReqAddr); end
    tick();
    tick();
    testsRun++; if (sInstrValid !== 1'b1 || sInstrPc !== 32'hFFFF_FFFC || sInstr !== memWord(32'hFFFF_FFFC)) begin testsFailed++; $display("[TB] FAIL wrap_word: got valid %b pc %h instr %h want 1 fffffffc %h", sInstrValid, sInstrPc, sInstr, memWord(32'hFFFF_FFFC)); end
    testsRun++; if (sReqValid !== 1'b1 || sReqAddr !== 32'h0) begin testsFailed++; $display("[TB] FAIL wrap_req_zero: got valid %b addr %h want 1 00000000", sReqValid, sReqAddr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    memLat = 3; instrReady = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    testsRun++; if (sReqValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_req_in_rst: got %b want 0", sReqValid); end
    rst = 1'b0; memLat = 1;
    tick();
    testsRun++; if (sInstrValid !== 1'b0 || sReqValid !== 1'b1 || sReqAddr !== 32'h0) begin testsFailed++; $display("[TB] FAIL rmid_after_wait_rst: got ivalid %b req %b addr %h want 0 1 00000000", sInstrValid, sReqValid, sReqAddr); end
    instrReady = 1'b0;
    tick();
    tick();
    testsRun++; if (sInstrValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rmid_setup_valid: got %b want 1", sInstrValid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    testsRun++; if (sInstrValid !== 1'b0 || sInstr !== 32'h0 || sInstrPc !== 32'h0) begin testsFailed++; $display("[TB] FAIL rmid_outputs_cleared: got valid %b instr %h pc %h want 0 00000000 00000000", sInstrValid, sInstr, sInstrPc); end
    testsRun++; if (sReqValid !== 1'b1 || sReqAddr !== 32'h0) begin testsFailed++; $display("[TB] FAIL rmid_req_reset_pc: got valid %b addr %h want 1 00000000", sReqValid, sReqAddr); end
  endtask

  // Reference: consumed words form a contiguous address run starting at RESET_PC or the latest redirect target.
  task automatic test_random();
    logic [31:0] expPc;
    int          consumed;
    bit          prevRedirect;
    do_reset();
    expPc = 32'h0; consumed = 0; prevRedirect = 0;
    for (int c = 0; c < 800; c++) begin
      instrReady   = ($urandom_range(0, 9) < 7);
      imemReqReady = ($urandom_range(0, 9) < 7);
      memLat       = $urandom_range(1, 3);
      redirEn      = ($urandom_range(0, 19) == 0);
      redirPc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      tick();
      if (prevRedirect) begin
        testsRun++; if (sInstrValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rand_valid_after_redirect@%0d: got %b want 0", c, sInstrValid); end
      end
      if (sInstrValid) begin
        testsRun++; if (sInstrPc !== expPc || sInstr !== memWord(expPc)) begin testsFailed++; $display("[TB] FAIL rand_word@%0d: got pc %h instr %h want pc %h instr %h", c, sInstrPc, sInstr, expPc, memWord(expPc)); end
      end
      if (sReqValid) begin
        testsRun++; if (sReqAddr !== expPc + (sInstrValid ? 32'd4 : 32'd0)) begin testsFailed++; $display("[TB] FAIL rand_req_addr@%0d: got %h want %h", c, sReqAddr, expPc + (sInstrValid ? 32'd4 : 32'd0)); end
      end
      if (redirEn || (sInstrValid && !instrReady)) begin
        testsRun++; if (sReqValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rand_req_blocked@%0d: got %b want 0", c, sReqValid); end
      end
      if (redirEn) expPc = redirPc & 32'hFFFF_FFFC;
      else if (sInstrValid && instrReady) begin
        expPc = expPc + 32'd4;
        consumed++;
      end
      prevRedirect = redirEn;
    end
    redirEn = 1'b0;
    testsRun++; if (consumed < 40) begin testsFailed++; $display("[TB] FAIL rand_progress: got %0d words want >= 40", consumed); end
  endtask

  initial begin
    rst = 1'b1; redirEn = 1'b0; redirPc = '0; instrReady = 1'b1; imemReqReady = 1'b1;
    imemRespValid = 1'b0; imemRespData = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
